tetris_nios_hex_bank: RTL and testbench

Avalon-MM slave that drives a bank of NUM_DIGITS seven-segment displays from one peripheral, replacing one single-digit output PIO per display. Each digit has its own register holding either a hex nibble, decoded in hardware, or raw segment bits, plus per-digit blank and blink flags. A shared programmable blink timer drives the blink flags. Sits on the Nios II data master next to the other board peripherals; out_port goes straight to the HEX pins.

---
 rtl/tetris_nios_hex_bank_pkg.sv | 54 +++++
 rtl/tetris_nios_hex_bank_if.sv | 18 +
 rtl/tetris_nios_hex_bank_blink_timer.sv | 50 +++++
 rtl/tetris_nios_hex_bank.sv | 158 +++++++++++++++
 tb/tb_tetris_nios_hex_bank.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/tetris_nios_hex_bank_pkg.sv
// tetris_nios_hex_pkg: register map, bit positions, digit register layout and
// the hex-to-seven-segment decode shared by the hex bank peripheral.
package tetris_nios_hex_pkg;

    // Word offsets of the control registers (digits occupy 0..NUM_DIGITS-1)
    localparam logic [3:0] ADDR_CTRL      = 4'd8;
    localparam logic [3:0] ADDR_BLINK_DIV = 4'd9;
    localparam logic [3:0] ADDR_STATUS    = 4'd10;

    // Bit positions inside DIGITn and CTRL
    localparam int DIGIT_RAW      = 7;
    localparam int DIGIT_BLANK    = 8;
    localparam int DIGIT_BLINK    = 9;
    localparam int CTRL_EN        = 0;
    localparam int CTRL_BLINK_RUN = 1;

    // Stored digit register; bits[3:0] double as the hex nibble
    typedef struct packed {
        logic       blink;
        logic       blank;
        logic       raw;
        logic [6:0] bits;
    } digit_t;

    // Active-high a..g pattern for a hex nibble (bit 0 = segment a)
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // Counter reload for a given half-period; a divider of 0 behaves as 1
    function automatic logic [31:0] blink_reload(input logic [31:0] div);
        return (div == 32'd0) ? 32'd0 : div - 32'd1;
    endfunction

endpackage

// File: rtl/tetris_nios_hex_bank_if.sv
// Avalon-MM slave bus of the hex bank (read latency 0, active-low write).
interface tetris_nios_hex_bank_if;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/tetris_nios_hex_bank_blink_timer.sv
// Shared blink timer: a 32-bit down-counter that flips phase each time it
// reaches zero and reloads from the half-period divider.
module tetris_nios_hex_blink_timer
    import tetris_nios_hex_pkg::*;
#(
    parameter logic [31:0] DIV_RST = 32'd25_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] div,
    input  logic        div_wr,
    output logic        phase
);

    logic [31:0] cnt_q, cnt_d;
    logic        phase_q, phase_d;

    // Next-state: stopped timer sits at reload with phase visible; a divider
    // write restarts the period with the value being written
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!run) begin
            cnt_d   = blink_reload(div);
            phase_d = 1'b0;
        end else if (div_wr) begin
            cnt_d   = blink_reload(div);
        end else if (cnt_q == 32'd0) begin
            cnt_d   = blink_reload(div);
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q - 32'd1;
        end
    end

    // Counter and phase registers; reset drops any partial period
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= blink_reload(DIV_RST);
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/tetris_nios_hex_bank.sv
// tetris_nios_hex_bank: Avalon-MM peripheral driving NUM_DIGITS seven-segment
// displays. Each digit is hex-decoded or raw, with blank and blink flags.
// Optional blink timer built when TETRIS_NIOS_HEX_BANK_BLINK_EN is defined;
// otherwise phase is 0, BLINK bits / CTRL[1] / BLINK_DIV / STATUS read 0.
module tetris_nios_hex_bank
    import tetris_nios_hex_pkg::*;
#(
    parameter int          NUM_DIGITS    = 6,
    parameter logic [31:0] BLINK_DIV_RST = 32'd25_000_000,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    tetris_nios_hex_bank_if.slave   bus,
    output logic [7*NUM_DIGITS-1:0] out_port
);

    localparam logic [7*NUM_DIGITS-1:0] OUT_OFF = {(7*NUM_DIGITS){ACTIVE_LOW}};

    logic                    wr_en;
    digit_t                  digit_q [NUM_DIGITS];
    digit_t                  digit_d [NUM_DIGITS];
    logic                    en_q, en_d;
    logic                    phase;
    logic [7*NUM_DIGITS-1:0] out_q, out_d;

    assign wr_en = bus.chipselect & ~bus.write_n;

    // Digit and enable next-state from bus writes
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_d[i] = digit_q[i];
            if (wr_en && int'(bus.address) == i) begin
                digit_d[i] = digit_t'(bus.writedata[9:0]);
`ifndef TETRIS_NIOS_HEX_BANK_BLINK_EN
                digit_d[i].blink = 1'b0;
`endif
            end
        end
        en_d = en_q;
        if (wr_en && bus.address == ADDR_CTRL) begin
            en_d = bus.writedata[CTRL_EN];
        end
    end

    // Digit and enable registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= '0;
            end
            en_q <= 1'b1;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= digit_d[i];
            end
            en_q <= en_d;
        end
    end

`ifdef TETRIS_NIOS_HEX_BANK_BLINK_EN
    logic        run_q, run_d;
    logic [31:0] div_q, div_d;
    logic        div_wr;

    // Blink control next-state from bus writes
    always_comb begin
        run_d  = run_q;
        div_d  = div_q;
        div_wr = wr_en && (bus.address == ADDR_BLINK_DIV);
        if (wr_en && bus.address == ADDR_CTRL) begin
            run_d = bus.writedata[CTRL_BLINK_RUN];
        end
        if (div_wr) begin
            div_d = bus.writedata;
        end
    end

    // Blink control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q <= 1'b0;
            div_q <= BLINK_DIV_RST;
        end else begin
            run_q <= run_d;
            div_q <= div_d;
        end
    end

    // The timer sees the divider value being written so a write reloads in the same edge
    tetris_nios_hex_blink_timer #(
        .DIV_RST (BLINK_DIV_RST)
    ) u_blink_timer (
        .clk    (clk),
        .reset  (reset),
        .run    (run_q),
        .div    (div_d),
        .div_wr (div_wr),
        .phase  (phase)
    );
`else
    logic unused_wdata;

    assign phase        = 1'b0;
    assign unused_wdata = ^bus.writedata[31:10];
`endif

    // Zero-latency read mux; no side effects
    always_comb begin
        bus.readdata = 32'd0;
        if (bus.chipselect) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (int'(bus.address) == i) begin
                    bus.readdata = {22'd0, digit_q[i]};
                end
            end
            case (bus.address)
`ifdef TETRIS_NIOS_HEX_BANK_BLINK_EN
                ADDR_CTRL:      bus.readdata = {30'd0, run_q, en_q};
                ADDR_BLINK_DIV: bus.readdata = div_q;
                ADDR_STATUS:    bus.readdata = {31'd0, phase};
`else
                ADDR_CTRL:      bus.readdata = {31'd0, en_q};
`endif
                default: ;
            endcase
        end
    end

    // Per-digit segment pattern with blanking and output polarity
    always_comb begin
        logic [6:0] seg;
        seg   = '0;
        out_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            seg = digit_q[i].raw ? digit_q[i].bits : hex_decode(digit_q[i].bits[3:0]);
            if (!en_q || digit_q[i].blank || (digit_q[i].blink && phase)) begin
                seg = 7'h00;
            end
            if (ACTIVE_LOW) begin
                seg = ~seg;
            end
            out_d[7*i +: 7] = seg;
        end
    end

    // Registered segment outputs, all-off in reset
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= OUT_OFF;
        end else begin
            out_q <= out_d;
        end
    end

    assign out_port = out_q;

endmodule

// File: tb/tb_tetris_nios_hex_bank.sv
// Directed bench for tetris_nios_hex_bank with default parameters
// (6 digits, ACTIVE_LOW=1). Blink steps depend on TETRIS_NIOS_HEX_BANK_BLINK_EN.
module tb_tetris_nios_hex_bank;

    localparam int NUM_DIGITS = 6;

    logic                    clk;
    logic                    reset;
    logic [7*NUM_DIGITS-1:0] out_port;
    int                      checks;
    int                      failures;
    logic [31:0]             rdat;

    tetris_nios_hex_bank_if bus_if ();

    tetris_nios_hex_bank dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus_if),
        .out_port (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [41:0] obs, input logic [41:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] dig(input int i);
        return out_port[7*i +: 7];
    endfunction

    // Single write cycle; returns at the falling edge after the write edge
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.address    = a;
        bus_if.writedata  = d;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    // Combinational read sampled mid low phase
    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_if.address    = a;
        bus_if.write_n    = 1'b1;
        bus_if.chipselect = 1'b1;
        #1;
        d = bus_if.readdata;
        bus_if.chipselect = 1'b0;
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        reset             = 1'b1;
        bus_if.address    = '0;
        bus_if.writedata  = '0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_out_all_off", 42'(out_port), {42{1'b1}});
        chk("reset_readdata_idle", 42'(bus_if.readdata), 42'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            chk($sformatf("post_reset_digit%0d", i), 42'(dig(i)), 42'h40);
        end
        rd(4'd8, rdat);
        chk("post_reset_ctrl", 42'(rdat), 42'h1);

        // Hex decode then raw on digit 2
        wr(4'd2, 32'h00B);
        @(negedge clk);
        chk("digit2_hex_b", 42'(dig(2)), 42'h03);
        wr(4'd2, 32'h0C9);
        @(negedge clk);
        chk("digit2_raw_49", 42'(dig(2)), 42'h36);
        rd(4'd2, rdat);
        chk("digit2_readback", 42'(rdat), 42'h0C9);

        // Blank, global disable, re-enable
        wr(4'd0, 32'h100);
        @(negedge clk);
        chk("digit0_blank", 42'(dig(0)), 42'h7F);
        chk("digit1_unaffected", 42'(dig(1)), 42'h40);
        wr(4'd8, 32'h0);
        @(negedge clk);
        chk("ctrl_en0_all_off", 42'(out_port), {42{1'b1}});
        wr(4'd8, 32'h1);
        @(negedge clk);
        chk("ctrl_en1_digit1", 42'(dig(1)), 42'h40);
        chk("ctrl_en1_digit2", 42'(dig(2)), 42'h36);

        // Unmapped and read-only writes
        wr(4'd12, 32'hFFFF_FFFF);
        wr(4'd10, 32'hFFFF_FFFF);
        rd(4'd12, rdat);
        chk("read_addr12", 42'(rdat), 42'd0);
        rd(4'd15, rdat);
        chk("read_addr15", 42'(rdat), 42'd0);
        rd(4'd0, rdat);
        chk("digit0_kept", 42'(rdat), 42'h100);
        rd(4'd8, rdat);
        chk("ctrl_kept", 42'(rdat), 42'h1);
        rd(4'd2, rdat);
        chk("digit2_kept", 42'(rdat), 42'h0C9);
        rd(4'd10, rdat);
        chk("status_idle", 42'(rdat), 42'd0);

`ifdef TETRIS_NIOS_HEX_BANK_BLINK_EN
        // Blink with half-period 4 on digit 1 showing '5'
        wr(4'd9, 32'd4);
        wr(4'd1, 32'h205);
        wr(4'd8, 32'h3);
        for (int m = 1; m <= 12; m++) begin
            @(negedge clk);
            bus_if.address    = 4'd10;
            bus_if.chipselect = 1'b1;
            #1;
            chk($sformatf("blink4_status_m%0d", m), 42'(bus_if.readdata), 42'(((m / 4) % 2)));
            chk($sformatf("blink4_digit1_m%0d", m), 42'(dig(1)),
                ((((m - 1) / 4) % 2) == 1) ? 42'h7F : 42'h12);
            bus_if.chipselect = 1'b0;
        end
        wr(4'd8, 32'h1);
        repeat (2) @(negedge clk);
        chk("blink_stop_digit1", 42'(dig(1)), 42'h12);
        rd(4'd10, rdat);
        chk("blink_stop_status", 42'(rdat), 42'd0);
        repeat (5) @(negedge clk);
        chk("blink_stop_digit1_hold", 42'(dig(1)), 42'h12);

        // Divider 0 toggles every cycle; reset clears it mid-run
        wr(4'd9, 32'd0);
        wr(4'd8, 32'h3);
        for (int m = 1; m <= 4; m++) begin
            @(negedge clk);
            bus_if.address    = 4'd10;
            bus_if.chipselect = 1'b1;
            #1;
            chk($sformatf("div0_status_m%0d", m), 42'(bus_if.readdata), 42'(m % 2));
            bus_if.chipselect = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        bus_if.address    = 4'd10;
        bus_if.chipselect = 1'b1;
        #1;
        chk("midrun_reset_status", 42'(bus_if.readdata), 42'd0);
        bus_if.chipselect = 1'b0;
        chk("midrun_reset_out", 42'(out_port), {42{1'b1}});
        reset = 1'b0;
        rd(4'd9, rdat);
        chk("midrun_reset_div", 42'(rdat), 42'd25_000_000);
        rd(4'd8, rdat);
        chk("midrun_reset_ctrl", 42'(rdat), 42'h1);
`else
        // Blink hardware absent: BLINK bits and CTRL[1] are dropped
        wr(4'd0, 32'h200);
        rd(4'd0, rdat);
        chk("noblink_digit0_read", 42'(rdat), 42'h000);
        chk("noblink_digit0_shown", 42'(dig(0)), 42'h40);
        wr(4'd8, 32'h3);
        rd(4'd8, rdat);
        chk("noblink_ctrl_read", 42'(rdat), 42'h1);
        wr(4'd9, 32'd4);
        rd(4'd9, rdat);
        chk("noblink_div_read", 42'(rdat), 42'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
